fp_addsub_sched: RTL and testbench

- Shares one fixed-latency FP add/sub pipeline between two requesters.
- Owns requester arbitration and issue into the pipeline.
- Tracks every in-flight operation, blocks a request whose destination register is already pending (WAW/RAW guard), and routes each result back to its originator.

---
 rtl/fp_addsub_sched_if.sv | 50 +++++
 rtl/fp_addsub_sched.sv | 120 ++++++++++++
 tb/tb_fp_addsub_sched.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_addsub_sched_if.sv
// Bundle of the two requester channels, the shared pipeline issue/return path and the
// response channel of the FP add/sub scheduler.
interface fp_addsub_sched_if #(
    parameter int unsigned DST_W = 4
);
    logic             req0_valid;
    logic             req0_ready;
    logic [31:0]      req0_a;
    logic [31:0]      req0_b;
    logic             req0_op;
    logic [DST_W-1:0] req0_dst;

    logic             req1_valid;
    logic             req1_ready;
    logic [31:0]      req1_a;
    logic [31:0]      req1_b;
    logic             req1_op;
    logic [DST_W-1:0] req1_dst;

    logic             pipe_valid;
    logic [31:0]      pipe_a;
    logic [31:0]      pipe_b;
    logic             pipe_op;
    logic [DST_W-1:0] pipe_dst;
    logic [31:0]      pipe_res;

    logic             rsp0_valid;
    logic             rsp1_valid;
    logic [31:0]      rsp_data;
    logic [DST_W-1:0] rsp_dst;

    // Requesters plus the pipeline datapath sit on the master side.
    modport master (
        output req0_valid, req0_a, req0_b, req0_op, req0_dst,
        output req1_valid, req1_a, req1_b, req1_op, req1_dst,
        output pipe_res,
        input  req0_ready, req1_ready,
        input  pipe_valid, pipe_a, pipe_b, pipe_op, pipe_dst,
        input  rsp0_valid, rsp1_valid, rsp_data, rsp_dst
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op, req0_dst,
        input  req1_valid, req1_a, req1_b, req1_op, req1_dst,
        input  pipe_res,
        output req0_ready, req1_ready,
        output pipe_valid, pipe_a, pipe_b, pipe_op, pipe_dst,
        output rsp0_valid, rsp1_valid, rsp_data, rsp_dst
    );
endinterface

// File: rtl/fp_addsub_sched.sv
// Two-requester scheduler for a shared fixed-latency FP add/sub pipeline: round-robin
// arbitration, destination-register hazard guard, in-flight tracking and result routing.
module fp_addsub_sched #(
    parameter int unsigned LAT     = 3,
    parameter int unsigned DST_W   = 4,
    parameter int unsigned MAX_OUT = 4
) (
    input logic              clk,
    input logic              reset,
    fp_addsub_sched_if.slave bus_io
);
    localparam int unsigned CntW = $clog2(MAX_OUT + 1);
    localparam int unsigned NReg = 2 ** DST_W;

    typedef struct packed {
        logic             vld;
        logic             id;
        logic [DST_W-1:0] dst;
    } trk_t;

    trk_t [LAT:0]     trk_q, trk_d;
    logic [NReg-1:0]  busy_q, busy_d;
    logic [CntW-1:0]  out_q, out_d;
    logic             ptr_q;

    logic             pipe_valid_q;
    logic [31:0]      pipe_a_q, pipe_b_q;
    logic             pipe_op_q;
    logic [DST_W-1:0] pipe_dst_q;
    logic             rsp0_q, rsp1_q;
    logic [31:0]      rsp_data_q;
    logic [DST_W-1:0] rsp_dst_q;

    logic             elig0, elig1, gnt0, gnt1, gnt, retire;
    logic [DST_W-1:0] gnt_dst;
    trk_t             tail;

    // Eligibility uses pre-edge busy, so a retiring dst cannot be re-granted in its own
    // retire cycle.
    assign elig0 = bus_io.req0_valid & ~busy_q[bus_io.req0_dst] & (out_q < CntW'(MAX_OUT));
    assign elig1 = bus_io.req1_valid & ~busy_q[bus_io.req1_dst] & (out_q < CntW'(MAX_OUT));
    assign gnt0  = elig0 & (~elig1 | ~ptr_q);
    assign gnt1  = elig1 & (~elig0 | ptr_q);
    assign gnt   = gnt0 | gnt1;
    assign gnt_dst = gnt1 ? bus_io.req1_dst : bus_io.req0_dst;

    assign tail   = trk_q[LAT];
    assign retire = tail.vld;

    assign bus_io.req0_ready = gnt0;
    assign bus_io.req1_ready = gnt1;
    assign bus_io.pipe_valid = pipe_valid_q;
    assign bus_io.pipe_a     = pipe_a_q;
    assign bus_io.pipe_b     = pipe_b_q;
    assign bus_io.pipe_op    = pipe_op_q;
    assign bus_io.pipe_dst   = pipe_dst_q;
    assign bus_io.rsp0_valid = rsp0_q;
    assign bus_io.rsp1_valid = rsp1_q;
    assign bus_io.rsp_data   = rsp_data_q;
    assign bus_io.rsp_dst    = rsp_dst_q;

    always_comb begin
        trk_d[0] = '{vld: gnt, id: gnt1, dst: gnt_dst};
        for (int i = 1; i <= int'(LAT); i++) begin
            trk_d[i] = trk_q[i-1];
        end
    end

    // Clear on retire first, then set on grant, so a set always wins.
    always_comb begin
        busy_d = busy_q;
        if (retire) busy_d[tail.dst] = 1'b0;
        if (gnt)    busy_d[gnt_dst]  = 1'b1;
    end

    always_comb begin
        out_d = out_q;
        unique case ({gnt, retire})
            2'b10:   out_d = out_q + CntW'(1);
            2'b01:   out_d = out_q - CntW'(1);
            default: out_d = out_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            trk_q        <= '0;
            busy_q       <= '0;
            out_q        <= '0;
            ptr_q        <= 1'b0;
            pipe_valid_q <= 1'b0;
            pipe_a_q     <= '0;
            pipe_b_q     <= '0;
            pipe_op_q    <= 1'b0;
            pipe_dst_q   <= '0;
            rsp0_q       <= 1'b0;
            rsp1_q       <= 1'b0;
            rsp_data_q   <= '0;
            rsp_dst_q    <= '0;
        end else begin
            trk_q        <= trk_d;
            busy_q       <= busy_d;
            out_q        <= out_d;
            pipe_valid_q <= gnt;
            if (gnt) begin
                ptr_q      <= gnt0;
                pipe_a_q   <= gnt1 ? bus_io.req1_a  : bus_io.req0_a;
                pipe_b_q   <= gnt1 ? bus_io.req1_b  : bus_io.req0_b;
                pipe_op_q  <= gnt1 ? bus_io.req1_op : bus_io.req0_op;
                pipe_dst_q <= gnt_dst;
            end
            rsp0_q <= retire & ~tail.id;
            rsp1_q <= retire & tail.id;
            if (retire) begin
                rsp_data_q <= bus_io.pipe_res;
                rsp_dst_q  <= tail.dst;
            end
        end
    end
endmodule

// File: tb/tb_fp_addsub_sched.sv
// Directed bench for fp_addsub_sched: a cycle-level reference model checks every output
// each cycle, and literal expectations pin grant/response timing for each scenario.
module tb_fp_addsub_sched;
    localparam int LAT   = 3;
    localparam int MAX_A = 5;
    localparam int MAX_B = 2;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        op;
        logic [3:0]  dst;
    } req_t;

    typedef struct {
        int          g;
        bit          id;
        logic [3:0]  dst;
        logic [31:0] a;
        logic [31:0] b;
        logic        op;
    } op_t;

    typedef struct {
        int          c;
        bit          id;
        logic [31:0] data;
        logic [3:0]  dst;
    } ev_t;

    logic clk = 1'b0;
    logic reset_a = 1'b1;
    logic reset_b = 1'b1;
    always #5 clk = ~clk;

    fp_addsub_sched_if #(.DST_W(4)) bus_a ();
    fp_addsub_sched_if #(.DST_W(4)) bus_b ();

    fp_addsub_sched #(.LAT(LAT), .DST_W(4), .MAX_OUT(MAX_A)) u_a (
        .clk    (clk),
        .reset  (reset_a),
        .bus_io (bus_a)
    );

    fp_addsub_sched #(.LAT(LAT), .DST_W(4), .MAX_OUT(MAX_B)) u_b (
        .clk    (clk),
        .reset  (reset_b),
        .bus_io (bus_b)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    req_t q0[$], q1[$];
    bit fire0 = 0, fire1 = 0;
    bit rst_plan = 1;
    logic [31:0] res_at [int];

    op_t infl[$];
    bit ptr = 0;
    logic [31:0] last_data = '0;
    logic [3:0] last_dst = '0;

    int g0log[$], g1log[$];
    ev_t rlog[$], plog[$];

    // Stand-in for the FP pipeline: known sums for the hand-checked vector, a scramble else.
    function automatic logic [31:0] stub_fn(logic [31:0] a, logic [31:0] b, logic op);
        if (a == 32'h3F800000 && b == 32'h40000000 && !op) return 32'h40400000;
        return a ^ {b[15:0], b[31:16]} ^ {31'd0, op};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic int at_or(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    // Pipeline stub: result appears LAT cycles after the issue strobe.
    initial forever begin
        @(negedge clk);
        if (bus_a.pipe_valid === 1'b1)
            res_at[cyc + LAT] = stub_fn(bus_a.pipe_a, bus_a.pipe_b, bus_a.pipe_op);
    end

    // Requester drivers for instance A, updated just after each rising edge.
    initial begin
        bus_a.req0_valid = 0; bus_a.req0_a = 0; bus_a.req0_b = 0; bus_a.req0_op = 0;
        bus_a.req0_dst = 0;
        bus_a.req1_valid = 0; bus_a.req1_a = 0; bus_a.req1_b = 0; bus_a.req1_op = 0;
        bus_a.req1_dst = 0;
        bus_a.pipe_res = 0;
        forever begin
            @(posedge clk);
            #1;
            if (fire0) void'(q0.pop_front());
            if (fire1) void'(q1.pop_front());
            fire0 = 0;
            fire1 = 0;
            reset_a = rst_plan;
            if (q0.size() > 0 && !rst_plan) begin
                bus_a.req0_valid = 1; bus_a.req0_a = q0[0].a; bus_a.req0_b = q0[0].b;
                bus_a.req0_op = q0[0].op; bus_a.req0_dst = q0[0].dst;
            end else begin
                bus_a.req0_valid = 0; bus_a.req0_a = 0; bus_a.req0_b = 0;
                bus_a.req0_op = 0; bus_a.req0_dst = 0;
            end
            if (q1.size() > 0 && !rst_plan) begin
                bus_a.req1_valid = 1; bus_a.req1_a = q1[0].a; bus_a.req1_b = q1[0].b;
                bus_a.req1_op = q1[0].op; bus_a.req1_dst = q1[0].dst;
            end else begin
                bus_a.req1_valid = 0; bus_a.req1_a = 0; bus_a.req1_b = 0;
                bus_a.req1_op = 0; bus_a.req1_dst = 0;
            end
            bus_a.pipe_res = res_at.exists(cyc) ? res_at[cyc] : (32'hBAD00000 ^ 32'(cyc));
        end
    end

    // Reference model: an op granted in cycle g occupies its dst and an outstanding slot in
    // cycles g+1..g+LAT+1, issues in g+1 and responds in g+LAT+2.
    task automatic model_cycle();
        int          c = cyc;
        logic [15:0] busy = '0;
        int          cnt = 0;
        bit          exp_pv = 0, ex0 = 0, ex1 = 0, el0, el1, e_r0, e_r1;
        op_t         pv;
        pv = '{0, 0, 4'd0, 32'd0, 32'd0, 1'b0};
        foreach (infl[i]) begin
            if (infl[i].g + 1 == c) begin exp_pv = 1; pv = infl[i]; end
            if (infl[i].g + 1 <= c && c <= infl[i].g + LAT + 1) begin
                busy[infl[i].dst] = 1'b1;
                cnt++;
            end
            if (infl[i].g + LAT + 2 == c) begin
                if (infl[i].id) ex1 = 1; else ex0 = 1;
                last_data = stub_fn(infl[i].a, infl[i].b, infl[i].op);
                last_dst  = infl[i].dst;
            end
        end
        chk("pipe_valid", 64'(bus_a.pipe_valid), 64'(exp_pv));
        if (exp_pv) begin
            chk("pipe_a", 64'(bus_a.pipe_a), 64'(pv.a));
            chk("pipe_b", 64'(bus_a.pipe_b), 64'(pv.b));
            chk("pipe_op", 64'(bus_a.pipe_op), 64'(pv.op));
            chk("pipe_dst", 64'(bus_a.pipe_dst), 64'(pv.dst));
        end
        chk("rsp0_valid", 64'(bus_a.rsp0_valid), 64'(ex0));
        chk("rsp1_valid", 64'(bus_a.rsp1_valid), 64'(ex1));
        chk("rsp_data", 64'(bus_a.rsp_data), 64'(last_data));
        chk("rsp_dst", 64'(bus_a.rsp_dst), 64'(last_dst));

        el0  = bus_a.req0_valid && !busy[bus_a.req0_dst] && cnt < MAX_A;
        el1  = bus_a.req1_valid && !busy[bus_a.req1_dst] && cnt < MAX_A;
        e_r0 = el0 && (!el1 || !ptr);
        e_r1 = el1 && (!el0 || ptr);
        chk("req0_ready", 64'(bus_a.req0_ready), 64'(e_r0));
        chk("req1_ready", 64'(bus_a.req1_ready), 64'(e_r1));
        if (e_r0) begin
            infl.push_back('{c, 1'b0, bus_a.req0_dst, bus_a.req0_a, bus_a.req0_b, bus_a.req0_op});
            ptr = 1;
        end else if (e_r1) begin
            infl.push_back('{c, 1'b1, bus_a.req1_dst, bus_a.req1_a, bus_a.req1_b, bus_a.req1_op});
            ptr = 0;
        end
        for (int i = infl.size() - 1; i >= 0; i--)
            if (infl[i].g + LAT + 2 <= c) infl.delete(i);

        fire0 = bus_a.req0_valid && bus_a.req0_ready;
        fire1 = bus_a.req1_valid && bus_a.req1_ready;
        if (fire0) g0log.push_back(c);
        if (fire1) g1log.push_back(c);
        if (bus_a.pipe_valid)
            plog.push_back('{c, 1'b0, bus_a.pipe_a, bus_a.pipe_dst});
        if (bus_a.rsp0_valid || bus_a.rsp1_valid)
            rlog.push_back('{c, bus_a.rsp1_valid, bus_a.rsp_data, bus_a.rsp_dst});
    endtask

    initial forever begin
        @(negedge clk);
        if (reset_a) begin
            infl.delete();
            ptr = 0;
            last_data = '0;
            last_dst = '0;
        end else begin
            model_cycle();
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic clear_logs();
        g0log.delete(); g1log.delete(); rlog.delete(); plog.delete();
    endtask

    task automatic do_reset();
        rst_plan = 1;
        step(2);
        rst_plan = 0;
    endtask

    int  base;
    logic [11:0] b_rdy, b_rsp;
    logic        b_r1;

    initial begin
        bus_b.req0_valid = 0; bus_b.req0_a = 0; bus_b.req0_b = 0; bus_b.req0_op = 0;
        bus_b.req0_dst = 0;
        bus_b.req1_valid = 0; bus_b.req1_a = 0; bus_b.req1_b = 0; bus_b.req1_op = 0;
        bus_b.req1_dst = 0;
        bus_b.pipe_res = 0;

        step(3);
        rst_plan = 0;
        step(1);
        chk("rst_pipe_ab", {bus_a.pipe_a, bus_a.pipe_b}, 64'd0);
        chk("rst_rsp_data", 64'(bus_a.rsp_data), 64'd0);
        chk("rst_ctl", 64'({bus_a.pipe_valid, bus_a.pipe_op, bus_a.pipe_dst, bus_a.rsp0_valid,
                            bus_a.rsp1_valid, bus_a.rsp_dst}), 64'd0);

        // Single add from requester 0.
        clear_logs();
        base = cyc + 1;
        q0.push_back('{32'h3F800000, 32'h40000000, 1'b0, 4'd3});
        step(8);
        chk("t1_grant_cyc", 64'(at_or(g0log, 0)), 64'(base));
        chk("t1_pipe_count", 64'(plog.size()), 64'd1);
        if (plog.size() > 0) begin
            chk("t1_pipe_cyc", 64'(plog[0].c), 64'(base + 1));
            chk("t1_pipe_dst", 64'(plog[0].dst), 64'd3);
        end
        chk("t1_rsp_count", 64'(rlog.size()), 64'd1);
        if (rlog.size() > 0) begin
            chk("t1_rsp_cyc", 64'(rlog[0].c), 64'(base + 5));
            chk("t1_rsp_id", 64'(rlog[0].id), 64'd0);
            chk("t1_rsp_data", 64'(rlog[0].data), 64'h40400000);
            chk("t1_rsp_dst", 64'(rlog[0].dst), 64'd3);
        end

        // Both requesters streaming distinct dsts: strict alternation from requester 0.
        do_reset();
        clear_logs();
        base = cyc + 1;
        for (int i = 0; i < 4; i++) begin
            q0.push_back('{32'h10000000 + 32'(i), 32'h20000000 + 32'(i), i[0], 4'(2 * i)});
            q1.push_back('{32'h30000000 + 32'(i), 32'h40000000 + 32'(i), ~i[0], 4'(2 * i + 1)});
        end
        step(16);
        for (int i = 0; i < 4; i++) begin
            chk("t2_grant0_cyc", 64'(at_or(g0log, i)), 64'(base + 2 * i));
            chk("t2_grant1_cyc", 64'(at_or(g1log, i)), 64'(base + 2 * i + 1));
        end
        chk("t2_rsp_count", 64'(rlog.size()), 64'd8);
        for (int k = 0; k < rlog.size() && k < 8; k++) begin
            chk("t2_rsp_cyc", 64'(rlog[k].c), 64'(base + k + 5));
            chk("t2_rsp_id", 64'(rlog[k].id), 64'(k % 2));
        end

        // Same dst back to back from one requester waits for the retire.
        clear_logs();
        base = cyc + 1;
        q0.push_back('{32'h00000005, 32'h00000050, 1'b0, 4'd5});
        q0.push_back('{32'h00000006, 32'h00000060, 1'b1, 4'd5});
        step(12);
        chk("t3_grant_a", 64'(at_or(g0log, 0)), 64'(base));
        chk("t3_grant_b", 64'(at_or(g0log, 1)), 64'(base + 5));
        if (rlog.size() > 0) chk("t3_rsp_cyc", 64'(rlog[0].c), 64'(base + 5));
        else chk("t3_rsp_count", 64'(rlog.size()), 64'd2);

        // Pointer sits at requester 1; both ask for dst 7.
        clear_logs();
        base = cyc + 1;
        q0.push_back('{32'h00000070, 32'h00000007, 1'b0, 4'd7});
        q1.push_back('{32'h00000071, 32'h00000017, 1'b1, 4'd7});
        step(12);
        chk("t4_grant1", 64'(at_or(g1log, 0)), 64'(base));
        chk("t4_grant0", 64'(at_or(g0log, 0)), 64'(base + 5));
        chk("t4_rsp_count", 64'(rlog.size()), 64'd2);
        if (rlog.size() > 1) begin
            chk("t4_rsp_first_id", 64'(rlog[0].id), 64'd1);
            chk("t4_rsp_second_cyc", 64'(rlog[1].c), 64'(base + 10));
        end

        // Reset with two ops in flight.
        clear_logs();
        base = cyc + 1;
        q0.push_back('{32'h00000080, 32'h00000008, 1'b0, 4'd8});
        q0.push_back('{32'h00000090, 32'h00000009, 1'b0, 4'd9});
        step(2);
        rst_plan = 1;
        step(1);
        rst_plan = 0;
        q0.push_back('{32'h00000081, 32'h00000018, 1'b1, 4'd8});
        q1.push_back('{32'h000000A0, 32'h0000000A, 1'b0, 4'd10});
        step(12);
        chk("t5_grant0_post", 64'(at_or(g0log, 2)), 64'(base + 3));
        chk("t5_grant1_post", 64'(at_or(g1log, 0)), 64'(base + 4));
        chk("t5_rsp_count", 64'(rlog.size()), 64'd2);
        if (rlog.size() > 0) begin
            chk("t5_rsp_cyc", 64'(rlog[0].c), 64'(base + 8));
            chk("t5_rsp_dst", 64'(rlog[0].dst), 64'd8);
        end

        // Instance B, MAX_OUT=2: requester 0 streams distinct dsts.
        @(posedge clk);
        #1;
        reset_b = 0;
        for (int k = 0; k < 12; k++) begin
            bus_b.req0_valid = 1;
            bus_b.req0_dst = 4'(k);
            bus_b.req0_a = 32'(k);
            bus_b.req0_b = 32'(k + 100);
            @(negedge clk);
            b_rdy[k] = bus_b.req0_ready;
            b_rsp[k] = bus_b.rsp0_valid;
            b_r1 = (k == 0) ? bus_b.rsp1_valid : (b_r1 | bus_b.rsp1_valid);
            @(posedge clk);
            #1;
        end
        bus_b.req0_valid = 0;
        chk("b_ready_pattern", 64'(b_rdy), 64'h0C63);
        chk("b_rsp0_pattern", 64'(b_rsp), 64'h0C60);
        chk("b_rsp1_quiet", 64'(b_r1), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
